// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB full-speed receive controller.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package usb_rx_pkg;

  // Receive sequencer states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC_WAIT,
    ST_PID_WAIT,
    ST_BYTE_WAIT,
    ST_STORE,
    ST_EOP_WAIT,
    ST_EOP_END,
    ST_ERR_FLUSH,
    ST_ERR_EOPEND
  } rx_state_e;

  // 4-bit PID codes (low nibble of the PID byte)
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    CLS_TOKEN,
    CLS_DATA,
    CLS_HANDSHAKE
  } pkt_class_e;

  // PID byte is good when the high nibble is the complement of a legal low nibble
  function automatic logic pid_ok(input logic [7:0] pid_byte);
    logic legal;
    case (pid_byte[3:0])
      PID_OUT, PID_IN, PID_DATA0, PID_DATA1,
      PID_ACK, PID_NAK, PID_STALL: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    return legal && (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

  // Illegal codes never reach here (pid_ok guards); they fall into handshake
  function automatic pkt_class_e pid_class(input logic [3:0] pid);
    pkt_class_e cls;
    case (pid)
      PID_OUT, PID_IN:      cls = CLS_TOKEN;
      PID_DATA0, PID_DATA1: cls = CLS_DATA;
      default:              cls = CLS_HANDSHAKE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// Bundle of RX-path inputs (timer, line decoder, shifter, FIFO status) and controller outputs.
// Wires only, no latency.
// fifo_full is the only backpressure; the controller turns it into a packet error.
// Optional err_count member exists only when USB_RX_ERR_CNT_EN is defined.
interface usb_rx_ctrl_if;
  logic       en_sample;
  logic       d_edge;
  logic       eop;
  logic [7:0] rcv_data;
  logic       byte_received;
  logic       fifo_full;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [3:0] rx_pid;
  logic       rx_packet_done;
`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] err_count;

  modport slave (
    input  en_sample, d_edge, eop, rcv_data, byte_received, fifo_full,
    output rcving, w_enable, r_error, rx_pid, rx_packet_done, err_count
  );
  modport master (
    output en_sample, d_edge, eop, rcv_data, byte_received, fifo_full,
    input  rcving, w_enable, r_error, rx_pid, rx_packet_done, err_count
  );
`else
  modport slave (
    input  en_sample, d_edge, eop, rcv_data, byte_received, fifo_full,
    output rcving, w_enable, r_error, rx_pid, rx_packet_done
  );
  modport master (
    output en_sample, d_edge, eop, rcv_data, byte_received, fifo_full,
    input  rcving, w_enable, r_error, rx_pid, rx_packet_done
  );
`endif
endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and count enable; holds at all-ones instead of wrapping.
// Count visible one cycle after count_enable.
// No flow control.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, then increment unless already at the top
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB FS receive sequencer: checks SYNC/PID, counts payload, gates RX FIFO writes, flags errors.
// All outputs registered: each reacts one clock after the triggering strobe.
// fifo_full on a data byte aborts the packet (no write, error flagged); no stall.
// Optional saturating error counter built only when USB_RX_ERR_CNT_EN is defined.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int         MAX_DATA_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE      = 8'h80
) (
  input  logic        clk,
  input  logic        n_rst,
  usb_rx_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_DATA_BYTES + 3);
  // Payload length includes the two CRC bytes
  localparam logic [CNT_W-1:0] TOKEN_LEN = CNT_W'(2);
  localparam logic [CNT_W-1:0] DATA_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DATA_MAX  = CNT_W'(MAX_DATA_BYTES + 2);

  rx_state_e        state_q, state_d;
  logic [3:0]       rx_pid_q, rx_pid_d;
  logic             r_error_q, r_error_d;
  logic             rcving_q, rcving_d;
  logic             w_enable_q, w_enable_d;
  logic             done_q, done_d;
  logic             cnt_clear, cnt_en;
  logic [CNT_W-1:0] byte_cnt;
  logic             eops, js, err_next;
  pkt_class_e       cls;

  assign eops = bus.en_sample & bus.eop;
  assign js   = bus.en_sample & ~bus.eop;
  assign cls  = pid_class(rx_pid_q);

  flex_counter #(.WIDTH(CNT_W)) u_byte_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .count_out    (byte_cnt)
  );

  // Next-state, counter control and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    rx_pid_d  = rx_pid_q;
    r_error_d = r_error_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.d_edge) begin
          state_d   = ST_SYNC_WAIT;
          r_error_d = 1'b0;
        end
      end
      ST_SYNC_WAIT: begin
        if (eops) begin
          state_d = ST_ERR_EOPEND;
        end else if (bus.byte_received) begin
          state_d = (bus.rcv_data == SYNC_BYTE) ? ST_PID_WAIT : ST_ERR_FLUSH;
        end
      end
      ST_PID_WAIT: begin
        if (eops) begin
          state_d = ST_ERR_EOPEND;
        end else if (bus.byte_received) begin
          if (pid_ok(bus.rcv_data)) begin
            rx_pid_d  = bus.rcv_data[3:0];
            cnt_clear = 1'b1;
            state_d   = (pid_class(bus.rcv_data[3:0]) == CLS_HANDSHAKE) ? ST_EOP_WAIT
                                                                       : ST_BYTE_WAIT;
          end else begin
            state_d = ST_ERR_FLUSH;
          end
        end
      end
      ST_BYTE_WAIT: begin
        if (eops) begin
          if ((cls == CLS_TOKEN) ? (byte_cnt == TOKEN_LEN) : (byte_cnt >= DATA_MIN)) begin
            state_d = ST_EOP_END;
          end else begin
            state_d = ST_ERR_EOPEND;
          end
        end else if (bus.byte_received) begin
          if (cls == CLS_TOKEN) begin
            if (byte_cnt >= TOKEN_LEN) begin
              state_d = ST_ERR_FLUSH;
            end else begin
              cnt_en = 1'b1;
            end
          end else if ((byte_cnt >= DATA_MAX) || bus.fifo_full) begin
            state_d = ST_ERR_FLUSH;
          end else begin
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        cnt_en  = 1'b1;
        state_d = ST_BYTE_WAIT;
      end
      ST_EOP_WAIT: begin
        if (eops) begin
          state_d = ST_EOP_END;
        end else if (bus.byte_received) begin
          state_d = ST_ERR_FLUSH;
        end
      end
      ST_EOP_END: begin
        // Second SE0 bit keeps us here; the J bit closes the packet
        if (js) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ERR_FLUSH: begin
        if (eops) begin
          state_d = ST_ERR_EOPEND;
        end
      end
      ST_ERR_EOPEND: begin
        if (js) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_next) begin
      r_error_d = 1'b1;
    end
  end

  assign err_next   = (state_d == ST_ERR_FLUSH) || (state_d == ST_ERR_EOPEND);
  assign rcving_d   = (state_d != ST_IDLE);
  assign w_enable_d = (state_d == ST_STORE);

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      rx_pid_q   <= 4'h0;
      r_error_q  <= 1'b0;
      rcving_q   <= 1'b0;
      w_enable_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_pid_q   <= rx_pid_d;
      r_error_q  <= r_error_d;
      rcving_q   <= rcving_d;
      w_enable_q <= w_enable_d;
      done_q     <= done_d;
    end
  end

  assign bus.rcving         = rcving_q;
  assign bus.w_enable       = w_enable_q;
  assign bus.r_error        = r_error_q;
  assign bus.rx_pid         = rx_pid_q;
  assign bus.rx_packet_done = done_q;

`ifdef USB_RX_ERR_CNT_EN
  logic       err_now;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_now = (state_q == ST_ERR_FLUSH) || (state_q == ST_ERR_EOPEND);

  // Count entries into the error states from a clean state, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_next && !err_now && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  // Build without the error counter: nothing extra to drive.
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl (MAX_DATA_BYTES=4): expected FIFO writes are
// queued as bytes are sent and checked against each w_enable strobe.
// Define USB_RX_ERR_CNT_EN to also check err_count.
module tb_usb_rx_ctrl;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_rx_ctrl_if bus ();

  usb_rx_ctrl #(.MAX_DATA_BYTES(4), .SYNC_BYTE(8'h80)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_cnt   = 0;
  int         done_cnt = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q[$];

  // Scoreboard: every write strobe must match the next queued byte
  always @(negedge clk) begin
    if (bus.w_enable === 1'b1) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_write: unexpected write of %h, required no write", bus.rcv_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rcv_data !== e) begin
          n_fail++;
          $display("FAIL fifo_write: data %h, required %h", bus.rcv_data, e);
        end
      end
    end
    if (bus.rx_packet_done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gap;
    tick;
    tick;
  endtask

  task automatic start_pkt;
    bus.d_edge = 1'b1;
    tick;
    bus.d_edge = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rcv_data      = b;
    bus.byte_received = 1'b1;
    tick;
    bus.byte_received = 1'b0;
  endtask

  task automatic eops_cycle;
    bus.en_sample = 1'b1;
    bus.eop       = 1'b1;
    tick;
    bus.en_sample = 1'b0;
    bus.eop       = 1'b0;
  endtask

  // Two SE0 bits then a J bit; returns right after the J is captured
  task automatic send_eop;
    eops_cycle;
    gap;
    eops_cycle;
    gap;
    bus.en_sample = 1'b1;
    bus.eop       = 1'b0;
    tick;
    bus.en_sample = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    gap;
    n_checks++; if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL reset_rcving: got %b, expected 0", bus.rcving); end
    n_checks++; if (bus.w_enable !== 1'b0) begin n_fail++; $display("FAIL reset_w_enable: got %b, expected 0", bus.w_enable); end
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL reset_r_error: got %b, expected 0", bus.r_error); end
    n_checks++; if (bus.rx_pid !== 4'h0) begin n_fail++; $display("FAIL reset_rx_pid: got %h, expected 0", bus.rx_pid); end
    n_checks++; if (bus.rx_packet_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", bus.rx_packet_done); end
`ifdef USB_RX_ERR_CNT_EN
    n_checks++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d, expected 0", bus.err_count); end
`endif
    n_rst = 1'b1;
    tick;
  endtask

  task automatic test_data0;
    logic [7:0] pay [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_pkt;
    n_checks++; if (bus.rcving !== 1'b1) begin n_fail++; $display("FAIL data0_rcving: got %b, expected 1", bus.rcving); end
    send_byte(8'h80); gap;
    send_byte(8'hC3);
    n_checks++; if (bus.rx_pid !== 4'h3) begin n_fail++; $display("FAIL data0_pid: got %h, expected 3", bus.rx_pid); end
    gap;
    foreach (pay[i]) begin
      exp_q.push_back(pay[i]);
      send_byte(pay[i]);
      gap;
    end
    send_eop;
    n_checks++; if (bus.rx_packet_done !== 1'b1) begin n_fail++; $display("FAIL data0_done: got %b, expected 1", bus.rx_packet_done); end
    n_checks++; if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL data0_rcving_end: got %b, expected 0", bus.rcving); end
    tick;
    n_checks++; if (wr_cnt - wr0 !== 4) begin n_fail++; $display("FAIL data0_writes: got %0d, expected 4", wr_cnt - wr0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL data0_done_cnt: got %0d, expected 1", done_cnt - d0); end
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL data0_r_error: got %b, expected 0", bus.r_error); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL data0_missing: %0d writes outstanding, expected 0", exp_q.size()); end
  endtask

  task automatic test_ack;
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_pkt;
    send_byte(8'h80); gap;
    send_byte(8'hD2);
    n_checks++; if (bus.rx_pid !== 4'h2) begin n_fail++; $display("FAIL ack_pid: got %h, expected 2", bus.rx_pid); end
    gap;
    send_eop;
    n_checks++; if (bus.rx_packet_done !== 1'b1) begin n_fail++; $display("FAIL ack_done: got %b, expected 1", bus.rx_packet_done); end
    tick;
    n_checks++; if (wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL ack_writes: got %0d, expected 0", wr_cnt - wr0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ack_done_cnt: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_bad_sync;
    start_pkt;
    send_byte(8'h81);
    exp_err++;
    n_checks++; if (bus.r_error !== 1'b1) begin n_fail++; $display("FAIL sync_r_error: got %b, expected 1", bus.r_error); end
    gap;
    send_eop;
    n_checks++; if (bus.rx_packet_done !== 1'b0) begin n_fail++; $display("FAIL sync_done: got %b, expected 0", bus.rx_packet_done); end
    tick;
  endtask

  task automatic test_bad_pid;
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_pkt;
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL pid_r_error_clear: got %b, expected 0", bus.r_error); end
    send_byte(8'h80); gap;
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL pid_r_error_early: got %b, expected 0", bus.r_error); end
    send_byte(8'hC2);
    exp_err++;
    n_checks++; if (bus.r_error !== 1'b1) begin n_fail++; $display("FAIL pid_r_error: got %b, expected 1", bus.r_error); end
    gap;
    send_eop;
    n_checks++; if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL pid_rcving: got %b, expected 0", bus.rcving); end
    tick;
    n_checks++; if (bus.r_error !== 1'b1) begin n_fail++; $display("FAIL pid_r_error_hold: got %b, expected 1", bus.r_error); end
    n_checks++; if (wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL pid_writes: got %0d, expected 0", wr_cnt - wr0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL pid_done_cnt: got %0d, expected 0", done_cnt - d0); end
`ifdef USB_RX_ERR_CNT_EN
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL pid_err_count: got %0d, expected %0d", bus.err_count, exp_err); end
`endif
    // Back-to-back: a new packet clears the sticky error and completes cleanly
    start_pkt;
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL pid_r_error_cleared: got %b, expected 0", bus.r_error); end
    send_byte(8'h80); gap;
    send_byte(8'h5A); gap;
    send_eop;
    n_checks++; if (bus.rx_packet_done !== 1'b1) begin n_fail++; $display("FAIL nak_done: got %b, expected 1", bus.rx_packet_done); end
    n_checks++; if (bus.rx_pid !== 4'hA) begin n_fail++; $display("FAIL nak_pid: got %h, expected a", bus.rx_pid); end
    tick;
  endtask

  task automatic test_overflow;
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    logic [7:0] b;
    start_pkt;
    send_byte(8'h80); gap;
    send_byte(8'h4B); gap;
    for (int i = 0; i < 7; i++) begin
      b = 8'hA0 + 8'(i);
      if (i < 6) exp_q.push_back(b);
      send_byte(b);
      if (i == 5) begin
        n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL ovf_r_error_early: got %b, expected 0", bus.r_error); end
      end
      gap;
    end
    exp_err++;
    n_checks++; if (bus.r_error !== 1'b1) begin n_fail++; $display("FAIL ovf_r_error: got %b, expected 1", bus.r_error); end
    send_eop;
    n_checks++; if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got %b, expected 0", bus.rcving); end
    tick;
    n_checks++; if (wr_cnt - wr0 !== 6) begin n_fail++; $display("FAIL ovf_writes: got %0d, expected 6", wr_cnt - wr0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL ovf_done_cnt: got %0d, expected 0", done_cnt - d0); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ovf_missing: %0d writes outstanding, expected 0", exp_q.size()); end
`ifdef USB_RX_ERR_CNT_EN
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL ovf_err_count: got %0d, expected %0d", bus.err_count, exp_err); end
`endif
  endtask

  task automatic test_fifo_full;
    int wr0 = wr_cnt;
    start_pkt;
    send_byte(8'h80); gap;
    send_byte(8'hC3); gap;
    exp_q.push_back(8'hA1);
    send_byte(8'hA1); gap;
    bus.fifo_full = 1'b1;
    send_byte(8'hA2);
    exp_err++;
    n_checks++; if (bus.r_error !== 1'b1) begin n_fail++; $display("FAIL full_r_error: got %b, expected 1", bus.r_error); end
    n_checks++; if (bus.w_enable !== 1'b0) begin n_fail++; $display("FAIL full_w_enable: got %b, expected 0", bus.w_enable); end
    bus.fifo_full = 1'b0;
    gap;
    send_eop;
    n_checks++; if (bus.rx_packet_done !== 1'b0) begin n_fail++; $display("FAIL full_done: got %b, expected 0", bus.rx_packet_done); end
    tick;
    n_checks++; if (wr_cnt - wr0 !== 1) begin n_fail++; $display("FAIL full_writes: got %0d, expected 1", wr_cnt - wr0); end
  endtask

  task automatic test_token;
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_pkt;
    send_byte(8'h80); gap;
    send_byte(8'h69);
    n_checks++; if (bus.rx_pid !== 4'h9) begin n_fail++; $display("FAIL in_pid: got %h, expected 9", bus.rx_pid); end
    gap;
    send_byte(8'h01); gap;
    eops_cycle;
    exp_err++;
    n_checks++; if (bus.r_error !== 1'b1) begin n_fail++; $display("FAIL short_token_r_error: got %b, expected 1", bus.r_error); end
    gap;
    send_eop;
    tick;
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL short_token_done: got %0d, expected 0", done_cnt - d0); end
`ifdef USB_RX_ERR_CNT_EN
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL token_err_count: got %0d, expected %0d", bus.err_count, exp_err); end
`endif
    // Complete OUT token with exactly two bytes
    start_pkt;
    send_byte(8'h80); gap;
    send_byte(8'hE1); gap;
    send_byte(8'h05); gap;
    send_byte(8'h06); gap;
    send_eop;
    n_checks++; if (bus.rx_packet_done !== 1'b1) begin n_fail++; $display("FAIL out_done: got %b, expected 1", bus.rx_packet_done); end
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL out_r_error: got %b, expected 0", bus.r_error); end
    n_checks++; if (bus.rx_pid !== 4'h1) begin n_fail++; $display("FAIL out_pid: got %h, expected 1", bus.rx_pid); end
    tick;
    n_checks++; if (wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL token_writes: got %0d, expected 0", wr_cnt - wr0); end
  endtask

  task automatic test_reset_mid;
    start_pkt;
    send_byte(8'h80); gap;
    send_byte(8'hC3); gap;
    exp_q.push_back(8'h55);
    send_byte(8'h55); gap;
    n_rst = 1'b0;
    exp_err = 0;
    #1;
    n_checks++; if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rcving: got %b, expected 0", bus.rcving); end
    n_checks++; if (bus.rx_pid !== 4'h0) begin n_fail++; $display("FAIL mid_rst_pid: got %h, expected 0", bus.rx_pid); end
    n_checks++; if (bus.w_enable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_w_enable: got %b, expected 0", bus.w_enable); end
    n_checks++; if (bus.r_error !== 1'b0) begin n_fail++; $display("FAIL mid_rst_r_error: got %b, expected 0", bus.r_error); end
`ifdef USB_RX_ERR_CNT_EN
    n_checks++; if (bus.err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL mid_rst_err_count: got %0d, expected %0d", bus.err_count, exp_err); end
`endif
    gap;
    n_rst = 1'b1;
    gap;
    n_checks++; if (bus.rcving !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %b, expected 0", bus.rcving); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL mid_rst_missing: %0d writes outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    n_rst             = 1'b0;
    bus.en_sample     = 1'b0;
    bus.d_edge        = 1'b0;
    bus.eop           = 1'b0;
    bus.rcv_data      = 8'h00;
    bus.byte_received = 1'b0;
    bus.fifo_full     = 1'b0;
    test_reset;
    test_data0;
    test_ack;
    test_bad_sync;
    test_bad_pid;
    test_overflow;
    test_fifo_full;
    test_token;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive control unit for the USB full-speed RX path. It sequences each packet, using the sample strobe from the RX timer, the decoded bus condition and the bytes from the RX shift register. It checks SYNC and PID, counts payload bytes, and gates writes into the RX FIFO. It reports packet completion, the decoded PID and protocol errors to the endpoint logic.

## Interface
- MAX_DATA_BYTES, 64: maximum data-packet payload bytes, excluding the 2 CRC16 bytes.
- SYNC_BYTE, 8'h80: required first byte (LSB-first assembled).
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- en_sample  in  1  one-cycle bit-sample strobe from the RX timer.
- d_edge  in  1  line transition detected this cycle.
- eop  in  1  SE0 on line; meaningful only when en_sample=1.
- rcv_data  in  8  last complete byte from shift register; stable until the next byte_received.
- byte_received  in  1  one-cycle pulse when 8 bits have been shifted.
- fifo_full  in  1  RX FIFO cannot accept a write.
- rcving  out  1  packet in progress.
- w_enable  out  1  one-cycle RX FIFO write strobe; FIFO captures rcv_data.
- r_error  out  1  sticky error flag for the last packet.
- rx_pid  out  4  PID of the last accepted packet.
- rx_packet_done  out  1  one-cycle pulse on an error-free packet end.

## Operation
- Definitions:
  - EOPS = en_sample & eop.
  - JS = en_sample & !eop.
  - Legal PIDs: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - The PID byte passes when rcv_data[7:4] == ~rcv_data[3:0], and rcv_data[3:0] is a legal PID.
- Packet classes and following bytes:
  - TOKEN (IN/OUT): exactly 2 bytes, counted, not written.
  - DATA: 2..MAX_DATA_BYTES+2 bytes, each written to the FIFO.
  - HANDSHAKE: 0 bytes.
- States and transitions:
  - IDLE: on d_edge → SYNC_WAIT, and r_error clears.
  - SYNC_WAIT: on byte_received, rcv_data==SYNC_BYTE → PID_WAIT, otherwise → ERR_FLUSH. On EOPS → ERR_EOPEND.
  - PID_WAIT: on byte_received, a passing PID latches rx_pid and clears the byte counter. Then DATA/TOKEN → BYTE_WAIT and HANDSHAKE → EOP_WAIT. A failing PID → ERR_FLUSH. On EOPS → ERR_EOPEND.
  - BYTE_WAIT, on byte_received:
    - Count overflow (TOKEN >2, DATA >MAX_DATA_BYTES+2) → ERR_FLUSH.
    - DATA with fifo_full → ERR_FLUSH, no write.
    - DATA otherwise → STORE.
    - TOKEN: increment the count and stay.
  - BYTE_WAIT, on EOPS: count legal (TOKEN ==2, DATA >=2) → EOP_END, otherwise → ERR_EOPEND.
  - STORE: one cycle with w_enable=1; increment the count; → BYTE_WAIT.
  - EOP_WAIT: EOPS → EOP_END; byte_received → ERR_FLUSH.
  - EOP_END: EOPS → stay (second SE0 bit); JS → IDLE and pulse rx_packet_done.
  - ERR_FLUSH: EOPS → ERR_EOPEND; byte_received is ignored.
  - ERR_EOPEND: EOPS → stay; JS → IDLE.
- r_error sets on any entry to ERR_FLUSH or ERR_EOPEND. It holds through IDLE until the next d_edge in IDLE.
- Priority: EOPS beats byte_received in the same cycle. d_edge is ignored outside IDLE.
- Outputs are registered. rcving is 1 in every state except IDLE.

## Timing
- Reset values: state IDLE, rcving=0, w_enable=0, r_error=0, rx_pid=4'h0, rx_packet_done=0, byte count 0.
- w_enable is high exactly one clock, in the cycle after the byte_received pulse.
- rx_pid updates in the cycle after the accepted PID byte_received.
- rx_packet_done pulses in the cycle after the JS that ends the packet. rcving falls in that same cycle.
- r_error rises in the cycle after the error is detected.
- Reset during a packet returns everything to reset values. Bytes already written stay in the FIFO.
- Byte counter width is $clog2(MAX_DATA_BYTES+3) and it never wraps. Overflow is detected at MAX_DATA_BYTES+3.

## Configuration
- USB_RX_ERR_CNT_EN defined:
  - Adds output err_count, 8 bits, reset 0.
  - It increments once per ERR_FLUSH/ERR_EOPEND entry from a non-error state and saturates at 255.
- USB_RX_ERR_CNT_EN undefined: no err_count port and no counter logic.

## Structure
- Package usb_rx_pkg holds:
  - the state enum;
  - the PID localparams;
  - the packet-class enum (TOKEN/DATA/HANDSHAKE);
  - the functions pid_ok() and pid_class().
- The byte counter is one instance of flex_counter, used with clear and count_enable only. Count bounds are compared externally.

## Test plan
- DATA0 packet: SYNC 80, PID C3, bytes 11 22 33 44, 2×SE0 then J → w_enable pulses exactly 4 times, rx_pid=3, one rx_packet_done, r_error=0.
- ACK packet: SYNC, PID D2, EOP → rx_pid=2, no w_enable, rx_packet_done pulses.
- Bad PID byte C2 → r_error=1 from the next cycle; no writes; no rx_packet_done. A new d_edge clears r_error.
- Data packet with MAX_DATA_BYTES=4 and 7 bytes after the PID → 6 writes, then ERR_FLUSH, then r_error=1 and IDLE after the EOP. With USB_RX_ERR_CNT_EN, err_count=1.
- fifo_full=1 on the 2nd data byte → 1 write only, r_error=1.
- IN token with only 1 following byte, then EOP → r_error=1, no writes. Reset asserted mid-packet → all outputs at reset values.
